// File: rtl/i2c_byte_ctrl.sv
// Byte-level I2C master sequencer: splits host byte commands into bit-controller START/WRITE/READ/STOP commands.
// Latency: one bit command per core_ack. cmd_ack pulses one cycle after the final core_ack of a byte command.
// Backpressure: each core_cmd is held until core_ack. Host requests are levels and are masked while cmd_ack is high.
module i2c_byte_ctrl (
  input  logic       clk,
  input  logic       nReset,
  input  logic       start,
  input  logic       stop,
  input  logic       read,
  input  logic       write,
  input  logic       ack_in,
  input  logic [7:0] din,
  output logic       cmd_ack,
  output logic       ack_out,
  output logic [7:0] dout,
  output logic       i2c_busy,
  output logic       i2c_al,
  output logic [3:0] core_cmd,
  output logic       core_txd,
  input  logic       core_ack,
  input  logic       core_rxd,
  input  logic       bit_busy,
  input  logic       bit_al
);

  localparam logic [3:0] CMD_NOP   = 4'b0000;
  localparam logic [3:0] CMD_START = 4'b0001;
  localparam logic [3:0] CMD_STOP  = 4'b0010;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_READ  = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WRITE,
    ST_READ,
    ST_ACK,
    ST_STOP
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] core_cmd_q, core_cmd_d;
  logic       core_txd_q, core_txd_d;
  logic       cmd_ack_q, cmd_ack_d;
  logic       ack_out_q, ack_out_d;
  logic [7:0] dout_q, dout_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic       go;

  // The cmd_ack mask keeps a still-asserted request from relaunching in the completion cycle.
  assign go = (read | write | stop) & ~cmd_ack_q;

  assign cmd_ack  = cmd_ack_q;
  assign ack_out  = ack_out_q;
  assign dout     = dout_q;
  assign core_cmd = core_cmd_q;
  assign core_txd = core_txd_q;
  assign i2c_busy = bit_busy;
  assign i2c_al   = bit_al;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q    <= ST_IDLE;
      core_cmd_q <= CMD_NOP;
      core_txd_q <= 1'b0;
      cmd_ack_q  <= 1'b0;
      ack_out_q  <= 1'b0;
      dout_q     <= 8'h00;
      shift_q    <= 8'h00;
      cnt_q      <= 3'd0;
    end else begin
      state_q    <= state_d;
      core_cmd_q <= core_cmd_d;
      core_txd_q <= core_txd_d;
      cmd_ack_q  <= cmd_ack_d;
      ack_out_q  <= ack_out_d;
      dout_q     <= dout_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state and command sequencing; arbitration loss overrides everything.
  always_comb begin
    state_d    = state_q;
    core_cmd_d = core_cmd_q;
    core_txd_d = core_txd_q;
    cmd_ack_d  = 1'b0;
    ack_out_d  = ack_out_q;
    dout_d     = dout_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;

    if (bit_al) begin
      state_d    = ST_IDLE;
      core_cmd_d = CMD_NOP;
      core_txd_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (go) begin
            shift_d = din;
            cnt_d   = 3'd7;
            if (start) begin
              state_d    = ST_START;
              core_cmd_d = CMD_START;
            end else if (read) begin
              state_d    = ST_READ;
              core_cmd_d = CMD_READ;
            end else if (write) begin
              state_d    = ST_WRITE;
              core_cmd_d = CMD_WRITE;
              core_txd_d = din[7];
            end else begin
              state_d    = ST_STOP;
              core_cmd_d = CMD_STOP;
            end
          end
        end

        ST_START: begin
          if (core_ack) begin
            if (read) begin
              state_d    = ST_READ;
              core_cmd_d = CMD_READ;
            end else if (write) begin
              state_d    = ST_WRITE;
              core_cmd_d = CMD_WRITE;
              core_txd_d = din[7];
            end else begin
              // START with only a stop request: close the bus rather than hang.
              state_d    = ST_STOP;
              core_cmd_d = CMD_STOP;
            end
          end
        end

        ST_WRITE, ST_READ: begin
          if (core_ack) begin
            shift_d = {shift_q[6:0], core_rxd};
            cnt_d   = cnt_q - 3'd1;
            if (cnt_q == 3'd0) begin
              state_d = ST_ACK;
              if (state_q == ST_WRITE) begin
                core_cmd_d = CMD_READ;
              end else begin
                core_cmd_d = CMD_WRITE;
                core_txd_d = ack_in;
              end
            end else if (state_q == ST_WRITE) begin
              core_txd_d = shift_q[6];
            end
          end
        end

        ST_ACK: begin
          if (core_ack) begin
            // The ACK slot is a READ only when the byte was a write.
            if (core_cmd_q == CMD_READ) begin
              ack_out_d = core_rxd;
            end
            dout_d     = shift_q;
            core_txd_d = 1'b1;
            if (stop) begin
              state_d    = ST_STOP;
              core_cmd_d = CMD_STOP;
            end else begin
              state_d    = ST_IDLE;
              core_cmd_d = CMD_NOP;
              cmd_ack_d  = 1'b1;
            end
          end
        end

        ST_STOP: begin
          if (core_ack) begin
            state_d    = ST_IDLE;
            core_cmd_d = CMD_NOP;
            cmd_ack_d  = 1'b1;
          end
        end

        default: begin
          state_d    = ST_IDLE;
          core_cmd_d = CMD_NOP;
        end
      endcase
    end
  end

endmodule
